mem_stage: RTL and testbench

Pipeline memory stage sitting directly after the execute stage. It consumes the EX/MEM register outputs, performs loads and stores over a req/ack data-memory handshake that tolerates variable latency, and selects the write-back value from three sources: ALU result, load data, or TPU `cout`. It drives the MEM/WB registers, and also drives the hazard unit's memory-stage destination, valid and forwarding signals.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/mem_stage_dmem_handshake.sv | 105 ++++++++++
 rtl/mem_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_stage.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types for the memory stage
//
// Contents:
//   REG_ADDR_W   register-file address width
//   mem_state_t  data-memory handshake states (IDLE, WAIT)
//   wb_src_t     write-back source encoding (ALU result, load data, TPU cout)
//   wb_src_sel   priority select of the write-back source
//   word_align   clears the byte-offset bits of an address
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MEM = 2'd1,
        WB_SRC_TPU = 2'd2
    } wb_src_t;

    // TPU read wins over a load, a load wins over the ALU result.
    function automatic wb_src_t wb_src_sel(input logic tpu_read, input logic wb_sel);
        if (tpu_read) begin
            return WB_SRC_TPU;
        end
        if (wb_sel) begin
            return WB_SRC_MEM;
        end
        return WB_SRC_ALU;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mem_stage_dmem_handshake.sv
// rtl/mem_stage_dmem_handshake.sv - req/ack data-memory handshake with timeout
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   op                  a memory op is waiting to be issued from EX/MEM
//   flush, stall        hazard-unit controls; only block a new issue
//   op_addr/op_wdata/op_we   access fields straight from EX/MEM
//   dmem_ack            access complete (ignored while dmem_req is low)
//   dmem_req/dmem_we/dmem_addr/dmem_wdata   memory request side
//   waiting             an access is outstanding (state WAIT)
//   done                an access completes this cycle (req and ack)
//   timeout             the outstanding access is abandoned this cycle
//   err                 sticky timeout flag, cleared only by reset
module dmem_handshake
    import pipe_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic        op_we,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        waiting,
    output logic        done,
    output logic        timeout,
    output logic        err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    mem_state_t  state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        err_q;
    logic        issue;

    // rst_n gates the issue path so the request is low for the whole reset,
    // not only once the state register has been cleared.
    assign issue   = rst_n && (state_q == IDLE) && op && !flush && !stall;
    assign waiting = (state_q == WAIT);

    // The counter holds the number of WAIT cycles already spent with the
    // request up; once it reaches the limit the request is dropped for the
    // cycle in which the stage leaves WAIT.
    assign timeout = waiting && (cnt_q == CW'(ACK_TIMEOUT));

    assign dmem_req   = issue || (waiting && !timeout);
    assign dmem_addr  = waiting ? addr_q  : word_align(op_addr);
    assign dmem_wdata = waiting ? wdata_q : op_wdata;
    assign dmem_we    = dmem_req && (waiting ? we_q : op_we);
    assign done       = dmem_req && dmem_ack;
    assign err        = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue && !dmem_ack) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                        addr_q  <= word_align(op_addr);
                        wdata_q <= op_wdata;
                        we_q    <= op_we;
                    end
                end
                WAIT: begin
                    // Flush is deliberately ignored here: a store already on
                    // the bus has to finish.
                    if (timeout) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                    end else if (dmem_ack) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: loads/stores, write-back select, MEM/WB
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   flush_i, stall_i      hazard unit: bubble / freeze the MEM/WB capture
//   result_i              ALU result, also the load/store address
//   read_data2_i          store data
//   cout_i                TPU read data
//   pc_i                  instruction PC
//   wb_sel_i, tpu_read_i  write-back source selects
//   reg_write_enable_i, mem_write_enable_i, reg_write_dst_i   EX/MEM controls
//   dmem_*                data-memory req/ack interface
//   wb_data_o, reg_write_enable_o, reg_write_dst_o, pc_o      MEM/WB registers
//   m_dest_reg_o, m_valid_o, m_fwd_data_o                     hazard/forwarding
//   err_o                 sticky access-timeout flag
module mem_stage
    import pipe_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  stall_i,
    input  logic [31:0]           result_i,
    input  logic [31:0]           read_data2_i,
    input  logic [31:0]           cout_i,
    input  logic [31:0]           pc_i,
    input  logic                  wb_sel_i,
    input  logic                  tpu_read_i,
    input  logic                  reg_write_enable_i,
    input  logic                  mem_write_enable_i,
    input  logic [REG_ADDR_W-1:0] reg_write_dst_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [31:0]           dmem_addr_o,
    output logic [31:0]           dmem_wdata_o,
    input  logic [31:0]           dmem_rdata_i,
    input  logic                  dmem_ack_i,
    output logic [31:0]           wb_data_o,
    output logic                  reg_write_enable_o,
    output logic [REG_ADDR_W-1:0] reg_write_dst_o,
    output logic [31:0]           pc_o,
    output logic [REG_ADDR_W-1:0] m_dest_reg_o,
    output logic                  m_valid_o,
    output logic [31:0]           m_fwd_data_o,
    output logic                  err_o
);

    logic                  op_present;
    logic                  op_live;
    logic                  waiting;
    logic                  done;
    logic                  timeout;
    logic                  pending;
    logic                  m_valid;
    logic                  kill_now;
    logic [31:0]           mem_data;
    logic [31:0]           wb_value;

    // Access resolved while MEM/WB was stalled: the op must not be issued a
    // second time, and its load data waits here until the stall releases.
    logic                  held_q;
    logic [31:0]           held_rdata_q;
    // A flush seen while the access was outstanding (or held) turns the
    // eventual completion into a bubble.
    logic                  kill_q;

    logic [31:0]           wb_data_q;
    logic                  reg_we_q;
    logic [REG_ADDR_W-1:0] dst_q;
    logic [31:0]           pc_q;

    assign op_present = mem_write_enable_i || (wb_sel_i && reg_write_enable_i);
    assign op_live    = op_present && !held_q;

    dmem_handshake #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_handshake (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .op         (op_live),
        .flush      (flush_i),
        .stall      (stall_i),
        .op_addr    (result_i),
        .op_wdata   (read_data2_i),
        .op_we      (mem_write_enable_i),
        .dmem_ack   (dmem_ack_i),
        .dmem_req   (dmem_req_o),
        .dmem_we    (dmem_we_o),
        .dmem_addr  (dmem_addr_o),
        .dmem_wdata (dmem_wdata_o),
        .waiting    (waiting),
        .done       (done),
        .timeout    (timeout),
        .err        (err_o)
    );

    // The stage is busy while an access is outstanding and not completing
    // this cycle. The cycle that completes or abandons an access reports
    // valid, so the upstream stall lifts on the same edge that retires the
    // op; otherwise the still-present op would be issued again.
    assign pending = (waiting && !done && !timeout)
                  || (!waiting && op_live && !done);
    assign m_valid = !pending;

    assign mem_data = held_q ? held_rdata_q : dmem_rdata_i;

    always_comb begin
        wb_value = result_i;
        case (wb_src_sel(tpu_read_i, wb_sel_i))
            WB_SRC_TPU: wb_value = cout_i;
            WB_SRC_MEM: wb_value = mem_data;
            default:    wb_value = result_i;
        endcase
    end

    assign kill_now = kill_q || flush_i || timeout;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_data_q    <= '0;
            reg_we_q     <= 1'b0;
            dst_q        <= '0;
            pc_q         <= '0;
            held_q       <= 1'b0;
            held_rdata_q <= '0;
            kill_q       <= 1'b0;
        end else if (!stall_i) begin
            wb_data_q <= wb_value;
            dst_q     <= reg_write_dst_i;
            pc_q      <= pc_i;
            reg_we_q  <= reg_write_enable_i && m_valid && !kill_now;
            held_q    <= 1'b0;
            if (m_valid) begin
                kill_q <= 1'b0;
            end else if (waiting && flush_i) begin
                kill_q <= 1'b1;
            end
        end else begin
            // Stall holds MEM/WB; anything resolving now is parked.
            if (done || timeout) begin
                held_q       <= 1'b1;
                held_rdata_q <= dmem_rdata_i;
            end
            if ((waiting && flush_i) || timeout || (held_q && flush_i)) begin
                kill_q <= 1'b1;
            end
        end
    end

    assign wb_data_o          = wb_data_q;
    assign reg_write_enable_o = reg_we_q;
    assign reg_write_dst_o    = dst_q;
    assign pc_o               = pc_q;
    assign m_dest_reg_o       = reg_write_dst_i;
    assign m_valid_o          = m_valid;
    assign m_fwd_data_o       = wb_value;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] result = '0;
    logic [31:0] rd2 = '0;
    logic [31:0] cout = '0;
    logic [31:0] pc = '0;
    logic        wb_sel = 1'b0;
    logic        tpu_read = 1'b0;
    logic        rwe = 1'b0;
    logic        mwe = 1'b0;
    logic [4:0]  dst = '0;
    logic [31:0] rdata = '0;
    logic        ack = 1'b0;

    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] wb_data_o;
    logic        reg_write_enable_o;
    logic [4:0]  reg_write_dst_o;
    logic [31:0] pc_o;
    logic [4:0]  m_dest_reg_o;
    logic        m_valid_o;
    logic [31:0] m_fwd_data_o;
    logic        err_o;

    mem_stage #(.ACK_TIMEOUT(64)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .flush_i            (flush),
        .stall_i            (stall),
        .result_i           (result),
        .read_data2_i       (rd2),
        .cout_i             (cout),
        .pc_i               (pc),
        .wb_sel_i           (wb_sel),
        .tpu_read_i         (tpu_read),
        .reg_write_enable_i (rwe),
        .mem_write_enable_i (mwe),
        .reg_write_dst_i    (dst),
        .dmem_req_o         (dmem_req_o),
        .dmem_we_o          (dmem_we_o),
        .dmem_addr_o        (dmem_addr_o),
        .dmem_wdata_o       (dmem_wdata_o),
        .dmem_rdata_i       (rdata),
        .dmem_ack_i         (ack),
        .wb_data_o          (wb_data_o),
        .reg_write_enable_o (reg_write_enable_o),
        .reg_write_dst_o    (reg_write_dst_o),
        .pc_o               (pc_o),
        .m_dest_reg_o       (m_dest_reg_o),
        .m_valid_o          (m_valid_o),
        .m_fwd_data_o       (m_fwd_data_o),
        .err_o              (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dst;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] pc_ctr = 32'h1000;
    logic        cap = 1'b0;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_TPU = 3, K_NOWR = 4, K_TPULD = 5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: a capture happens at every non-stalled edge out of reset;
    // each captured register write must match the oldest expectation.
    always @(posedge clk) cap <= rst_n && !stall;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (cap && rst_n && reg_write_enable_o) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected_write: got write pc=%h expected no write", pc_o);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", pc_o, e.pc);
                chk("sb_dst", reg_write_dst_o, e.dst);
                chk("sb_data", wb_data_o, e.data);
            end
        end
    end

    task automatic set_nop();
        rwe = 0; wb_sel = 0; tpu_read = 0; mwe = 0;
        result = '0; rd2 = '0; cout = '0; dst = '0;
    endtask

    task automatic set_op(input int kind, input logic [31:0] res, input logic [31:0] wd,
                          input logic [31:0] cv, input logic [4:0] d);
        set_nop();
        case (kind)
            K_ALU:   rwe = 1;
            K_LOAD:  begin rwe = 1; wb_sel = 1; end
            K_STORE: mwe = 1;
            K_TPU:   begin rwe = 1; tpu_read = 1; end
            K_TPULD: begin rwe = 1; wb_sel = 1; tpu_read = 1; end
            default: ;
        endcase
        result = res; rd2 = wd; cout = cv; dst = d;
        pc = pc_ctr;
        pc_ctr = pc_ctr + 4;
    endtask

    // Reference: source priority TPU > load > ALU; a write happens only for
    // register-writing ops that were not flushed.
    task automatic run_txn(input int kind, input logic [31:0] res, input logic [31:0] wd,
                           input logic [31:0] cv, input logic [4:0] d, input logic [31:0] rd,
                           input int lat, input bit fl);
        logic [31:0] expd;
        bit          is_mem;
        exp_t        e;
        set_op(kind, res, wd, cv, d);
        is_mem = (kind == K_LOAD) || (kind == K_STORE) || (kind == K_TPULD);
        expd = tpu_read ? cv : (wb_sel ? rd : res);
        if (rwe && !fl) begin
            e.pc = pc; e.dst = d; e.data = expd;
            sb.push_back(e);
        end
        if (!is_mem) begin
            flush = fl;
            @(negedge clk);
            ack = 1'($urandom_range(0, 1));
            rdata = $urandom;
            #1;
            chk("nonmem_req", dmem_req_o, 0);
            chk("nonmem_valid", m_valid_o, 1);
            chk("nonmem_fwd", m_fwd_data_o, expd);
            chk("nonmem_mdest", m_dest_reg_o, d);
            @(posedge clk); #1;
            flush = 0; ack = 0;
        end else begin
            for (int c = 0; c <= lat; c++) begin
                @(negedge clk);
                if (fl && c == 1) flush = 1;
                if (c == lat) begin ack = 1; rdata = rd; end
                #1;
                chk("mem_req", dmem_req_o, 1);
                chk("mem_addr", dmem_addr_o, res & 32'hFFFF_FFFC);
                chk("mem_we", dmem_we_o, (kind == K_STORE));
                if (kind == K_STORE) chk("mem_wdata", dmem_wdata_o, wd);
                chk("mem_valid", m_valid_o, (c == lat));
                if (c == lat) chk("mem_fwd", m_fwd_data_o, expd);
                @(posedge clk); #1;
                ack = 0; flush = 0; rdata = $urandom;
            end
        end
        set_nop();
    endtask

    initial begin
        int          bad;
        logic [31:0] tpu_pc;
        logic [31:0] v;
        int          lat;
        bit          fl;

        // Reset: an op on the inputs must not raise a request.
        set_op(K_LOAD, 32'h40, 0, 0, 3);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req", dmem_req_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_reg_we", reg_write_enable_o, 0);
        chk("rst_dst", reg_write_dst_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_err", err_o, 0);
        set_nop();
        @(posedge clk); #1;
        rst_n = 1;

        // ALU op, single-cycle.
        run_txn(K_ALU, 32'h1234, $urandom, $urandom, 5, $urandom, 0, 0);
        @(negedge clk); #1;
        chk("alu_wb_data", wb_data_o, 32'h1234);
        chk("alu_dst", reg_write_dst_o, 5);
        chk("alu_reg_we", reg_write_enable_o, 1);
        @(posedge clk); #1;

        // Load from an unaligned address, ack after three wait cycles.
        run_txn(K_LOAD, 32'h103, 0, 0, 7, 32'hDEADBEEF, 3, 0);
        @(negedge clk); #1;
        chk("load_wb_data", wb_data_o, 32'hDEADBEEF);
        chk("load_reg_we", reg_write_enable_o, 1);
        @(posedge clk); #1;

        // Zero-wait store.
        run_txn(K_STORE, 32'h200, 32'hA5A5, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("store_reg_we", reg_write_enable_o, 0);
        @(posedge clk); #1;

        // Flush while a store and then a load are outstanding.
        run_txn(K_STORE, 32'h304, 32'h5A5A, 0, 0, 0, 4, 1);
        run_txn(K_LOAD, 32'h308, 0, 0, 9, 32'h600DF00D, 3, 1);
        @(negedge clk); #1;
        chk("flush_load_reg_we", reg_write_enable_o, 0);
        @(posedge clk); #1;

        // TPU read, then stall holds MEM/WB while a new ALU op waits.
        run_txn(K_TPU, 32'h11, 0, 32'h77, 12, 0, 0, 0);
        tpu_pc = pc_ctr - 4;
        @(negedge clk); #1;
        chk("tpu_wb_data", wb_data_o, 32'h77);
        set_op(K_ALU, 32'hCAFE0001, 0, 0, 13);
        sb.push_back('{pc: pc, dst: 5'd13, data: 32'hCAFE0001});
        stall = 1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("stall_hold_data", wb_data_o, 32'h77);
            chk("stall_hold_pc", pc_o, tpu_pc);
            @(posedge clk); #1;
        end
        stall = 0;
        @(posedge clk); #1;
        set_nop();
        @(negedge clk); #1;
        chk("stall_release_data", wb_data_o, 32'hCAFE0001);

        // Load blocked by stall in IDLE, then acked while stalled.
        @(posedge clk); #1;
        set_op(K_LOAD, 32'h500, 0, 0, 21);
        sb.push_back('{pc: pc, dst: 5'd21, data: 32'hBEEF1234});
        stall = 1;
        @(negedge clk); #1;
        chk("stall_idle_req", dmem_req_o, 0);
        chk("stall_idle_valid", m_valid_o, 0);
        @(posedge clk); #1;
        stall = 0;
        @(negedge clk); #1;
        chk("stall_ld_issue", dmem_req_o, 1);
        @(posedge clk); #1;
        @(negedge clk);
        stall = 1; ack = 1; rdata = 32'hBEEF1234;
        #1;
        chk("stall_ld_ack_req", dmem_req_o, 1);
        chk("stall_ld_ack_valid", m_valid_o, 1);
        @(posedge clk); #1;
        ack = 0; rdata = $urandom;
        repeat (2) begin
            @(negedge clk); #1;
            chk("stall_ld_no_reissue", dmem_req_o, 0);
            chk("stall_ld_valid", m_valid_o, 1);
            @(posedge clk); #1;
        end
        stall = 0;
        @(negedge clk); #1;
        chk("stall_ld_release_req", dmem_req_o, 0);
        chk("stall_ld_fwd", m_fwd_data_o, 32'hBEEF1234);
        @(posedge clk); #1;
        set_nop();
        @(negedge clk); #1;
        chk("stall_ld_wb_data", wb_data_o, 32'hBEEF1234);
        @(posedge clk); #1;

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            lat = $urandom_range(0, 4);
            fl = (lat >= 1) && ($urandom_range(0, 3) == 0);
            run_txn($urandom_range(0, 5), $urandom, $urandom, $urandom,
                    5'($urandom_range(0, 31)), $urandom, lat, fl);
        end
        chk("pre_timeout_err", err_o, 0);

        // No ack: request held for the issue cycle plus 64 WAIT cycles.
        set_op(K_LOAD, $urandom, 0, 0, 30);
        bad = 0;
        for (int c = 0; c <= 64; c++) begin
            @(negedge clk); #1;
            if (dmem_req_o !== 1'b1) bad++;
            if (m_valid_o !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        chk("timeout_req_held_bad_cycles", bad, 0);
        @(negedge clk); #1;
        chk("timeout_req_dropped", dmem_req_o, 0);
        @(posedge clk); #1;
        set_nop();
        @(negedge clk); #1;
        chk("timeout_err", err_o, 1);
        chk("timeout_bubble", reg_write_enable_o, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            run_txn($urandom_range(0, 4), $urandom, $urandom, $urandom,
                    5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 2), 0);
        end
        chk("err_sticky", err_o, 1);

        // Reset in the middle of WAIT drops the request at once.
        set_op(K_STORE, 32'h700, 32'h1111, 0, 0);
        @(negedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("wait_req_before_rst", dmem_req_o, 1);
        rst_n = 0;
        #1;
        chk("async_rst_req", dmem_req_o, 0);
        chk("async_rst_err", err_o, 0);
        chk("async_rst_pc", pc_o, 0);
        chk("async_rst_reg_we", reg_write_enable_o, 0);
        set_nop();
        @(posedge clk); #1;
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        v = sb.size();
        chk("sb_drained", v, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
